// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - goal/clear inputs and score display outputs of the score keeper
//
// Purpose: bundles the puck/goal-side inputs and the display-side outputs of
//   score_keeper so that both ends connect through one port.
// Signals:
//   p1_goal   1  level, high while the puck is in player 2's net
//   p2_goal   1  level, high while the puck is in player 1's net
//   clear     1  synchronous new-game request, active high
//   p1_ones   4  P1 units digit, BCD 0..9
//   p1_tens   3  P1 tens digit, 0..7
//   p2_ones   4  P2 units digit, BCD 0..9
//   p2_tens   3  P2 tens digit, 0..7
//   serve     1  one-cycle pulse when the lockout ends
//   game_over 1  high while the game is over
//   winner    2  00 none, 01 P1, 10 P2
// Modports:
//   master  goal logic / host side: drives goals and clear, reads the score
//   slave   score keeper side
interface score_keeper_if;
  logic       p1_goal;
  logic       p2_goal;
  logic       clear;
  logic [3:0] p1_ones;
  logic [2:0] p1_tens;
  logic [3:0] p2_ones;
  logic [2:0] p2_tens;
  logic       serve;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output p1_goal, p2_goal, clear,
    input  p1_ones, p1_tens, p2_ones, p2_tens, serve, game_over, winner
  );

  modport slave (
    input  p1_goal, p2_goal, clear,
    output p1_ones, p1_tens, p2_ones, p2_tens, serve, game_over, winner
  );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - air hockey score keeper with goal lockout and game-over detection
//
// Purpose: converts per-player goal sensor levels into BCD score digits for the
//   seven-segment scanner. A counted goal starts a lockout so one puck crossing
//   scores once; reaching WIN_SCORE ends the game.
// Parameters:
//   WIN_SCORE       score that ends the game, 1..79
//   LOCKOUT_CYCLES  clk cycles goals are ignored after a counted goal, >=1
// Ports:
//   clk    in  system clock, posedge
//   rst_n  in  synchronous active-low reset
//   bus    score_keeper_if.slave (goal/clear inputs, digit/serve/game_over/winner outputs)
module score_keeper #(
  parameter int WIN_SCORE      = 7,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  score_keeper_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_SCORED = 2'd1,
    ST_OVER   = 2'd2
  } state_t;

  localparam int LP_CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LP_CW-1:0] LP_LOCK_LOAD = LP_CW'(LOCKOUT_CYCLES - 1);
  // Winning score in the same {tens, ones} BCD layout as the score registers.
  localparam logic [6:0] LP_WIN_BCD = {3'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  state_t           r_state;
  logic [LP_CW-1:0] r_lock_cnt;
  logic             r_p1_goal_q;
  logic             r_p2_goal_q;
  logic [3:0]       r_p1_ones;
  logic [2:0]       r_p1_tens;
  logic [3:0]       r_p2_ones;
  logic [2:0]       r_p2_tens;
  logic             r_serve;
  logic             r_game_over;
  logic [1:0]       r_winner;

  logic             w_p1_evt;
  logic             w_p2_evt;
  logic [6:0]       w_p1_next;
  logic [6:0]       w_p2_next;
  logic             w_p1_win;
  logic             w_p2_win;

  // BCD increment of a {tens, ones} pair. WIN_SCORE <= 79 keeps tens <= 7.
  function automatic logic [6:0] bcd_inc(input logic [6:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[6:4] + 3'd1, 4'd0};
    end else begin
      return {v[6:4], v[3:0] + 4'd1};
    end
  endfunction

  always_comb begin
    w_p1_evt  = bus.p1_goal & ~r_p1_goal_q;
    w_p2_evt  = bus.p2_goal & ~r_p2_goal_q;
    w_p1_next = bcd_inc({r_p1_tens, r_p1_ones});
    w_p2_next = bcd_inc({r_p2_tens, r_p2_ones});
    w_p1_win  = (w_p1_next == LP_WIN_BCD);
    w_p2_win  = (w_p2_next == LP_WIN_BCD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_PLAY;
      r_lock_cnt  <= '0;
      r_p1_goal_q <= 1'b0;
      r_p2_goal_q <= 1'b0;
      r_p1_ones   <= 4'd0;
      r_p1_tens   <= 3'd0;
      r_p2_ones   <= 4'd0;
      r_p2_tens   <= 3'd0;
      r_serve     <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 2'b00;
    end else begin
      // Edge registers track the sensors in every state, including during
      // clear, so a level held across a lockout or a new game never rescores.
      r_p1_goal_q <= bus.p1_goal;
      r_p2_goal_q <= bus.p2_goal;
      r_serve     <= 1'b0;

      if (bus.clear) begin
        r_state     <= ST_PLAY;
        r_lock_cnt  <= '0;
        r_p1_ones   <= 4'd0;
        r_p1_tens   <= 3'd0;
        r_p2_ones   <= 4'd0;
        r_p2_tens   <= 3'd0;
        r_game_over <= 1'b0;
        r_winner    <= 2'b00;
      end else begin
        case (r_state)
          ST_PLAY: begin
            if (w_p1_evt && !w_p2_evt) begin
              {r_p1_tens, r_p1_ones} <= w_p1_next;
              if (w_p1_win) begin
                r_state     <= ST_OVER;
                r_game_over <= 1'b1;
                r_winner    <= 2'b01;
              end else begin
                r_state    <= ST_SCORED;
                r_lock_cnt <= LP_LOCK_LOAD;
              end
            end else if (w_p2_evt && !w_p1_evt) begin
              {r_p2_tens, r_p2_ones} <= w_p2_next;
              if (w_p2_win) begin
                r_state     <= ST_OVER;
                r_game_over <= 1'b1;
                r_winner    <= 2'b10;
              end else begin
                r_state    <= ST_SCORED;
                r_lock_cnt <= LP_LOCK_LOAD;
              end
            end else if (w_p1_evt && w_p2_evt) begin
              // Simultaneous crossing is ambiguous: no point, but still lock out.
              r_state    <= ST_SCORED;
              r_lock_cnt <= LP_LOCK_LOAD;
            end
          end

          ST_SCORED: begin
            // Counter was loaded with LOCKOUT_CYCLES-1 on entry, so the state
            // is held for exactly LOCKOUT_CYCLES cycles before play resumes.
            if (r_lock_cnt == '0) begin
              r_state <= ST_PLAY;
              r_serve <= 1'b1;
            end else begin
              r_lock_cnt <= r_lock_cnt - 1'b1;
            end
          end

          ST_OVER: begin
            // Scores and winner frozen until clear or reset.
          end

          default: begin
            r_state <= ST_PLAY;
          end
        endcase
      end
    end
  end

  assign bus.p1_ones   = r_p1_ones;
  assign bus.p1_tens   = r_p1_tens;
  assign bus.p2_ones   = r_p2_ones;
  assign bus.p2_tens   = r_p2_tens;
  assign bus.serve     = r_serve;
  assign bus.game_over = r_game_over;
  assign bus.winner    = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper against a score-level reference model
module tb_score_keeper;

  localparam int LOCK = 16;

  logic       clk;
  logic [1:0] rstn;
  logic [1:0] p1;
  logic [1:0] p2;
  logic [1:0] clr;

  int n_tests;
  int n_fail;

  score_keeper_if if7();
  score_keeper_if if79();

  assign if7.p1_goal  = p1[0];
  assign if7.p2_goal  = p2[0];
  assign if7.clear    = clr[0];
  assign if79.p1_goal = p1[1];
  assign if79.p2_goal = p2[1];
  assign if79.clear   = clr[1];

  score_keeper #(.WIN_SCORE(7), .LOCKOUT_CYCLES(LOCK)) dut7 (
    .clk   (clk),
    .rst_n (rstn[0]),
    .bus   (if7)
  );

  score_keeper #(.WIN_SCORE(79), .LOCKOUT_CYCLES(LOCK)) dut79 (
    .clk   (clk),
    .rst_n (rstn[1]),
    .bus   (if79)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer scores, a "cycles of lockout left" count, and flags.
  int win_of[2];
  int m_sc1[2];
  int m_sc2[2];
  int m_lock_left[2];
  int m_over[2];
  int m_winner[2];
  int m_serve[2];
  int m_prev1[2];
  int m_prev2[2];
  int n_serve[2];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input int d);
    int e1;
    int e2;
    if (!rstn[d]) begin
      m_sc1[d] = 0; m_sc2[d] = 0; m_lock_left[d] = 0;
      m_over[d] = 0; m_winner[d] = 0; m_serve[d] = 0;
      m_prev1[d] = 0; m_prev2[d] = 0;
      return;
    end
    e1 = (p1[d] && !m_prev1[d]) ? 1 : 0;
    e2 = (p2[d] && !m_prev2[d]) ? 1 : 0;
    m_prev1[d] = int'(p1[d]);
    m_prev2[d] = int'(p2[d]);
    m_serve[d] = 0;
    if (clr[d]) begin
      m_sc1[d] = 0; m_sc2[d] = 0; m_lock_left[d] = 0;
      m_over[d] = 0; m_winner[d] = 0;
    end else if (m_over[d] != 0) begin
      // frozen
    end else if (m_lock_left[d] > 0) begin
      m_lock_left[d]--;
      if (m_lock_left[d] == 0) m_serve[d] = 1;
    end else if (e1 != 0 && e2 != 0) begin
      m_lock_left[d] = LOCK;
    end else if (e1 != 0) begin
      m_sc1[d]++;
      if (m_sc1[d] == win_of[d]) begin
        m_over[d] = 1; m_winner[d] = 1;
      end else begin
        m_lock_left[d] = LOCK;
      end
    end else if (e2 != 0) begin
      m_sc2[d]++;
      if (m_sc2[d] == win_of[d]) begin
        m_over[d] = 1; m_winner[d] = 2;
      end else begin
        m_lock_left[d] = LOCK;
      end
    end
  endtask

  task automatic check_dut(input int d, input int p1o, input int p1t, input int p2o,
                           input int p2t, input int srv, input int go, input int wn);
    string t;
    t = (d == 0) ? "w7" : "w79";
    check({t, ".p1_ones"},   p1o, m_sc1[d] % 10);
    check({t, ".p1_tens"},   p1t, m_sc1[d] / 10);
    check({t, ".p2_ones"},   p2o, m_sc2[d] % 10);
    check({t, ".p2_tens"},   p2t, m_sc2[d] / 10);
    check({t, ".serve"},     srv, m_serve[d]);
    check({t, ".game_over"}, go,  m_over[d]);
    check({t, ".winner"},    wn,  m_winner[d]);
  endtask

  // One clock: model consumes the inputs sampled at the edge, outputs checked 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (if7.serve)  n_serve[0]++;
    if (if79.serve) n_serve[1]++;
    check_dut(0, int'(if7.p1_ones), int'(if7.p1_tens), int'(if7.p2_ones), int'(if7.p2_tens),
              int'(if7.serve), int'(if7.game_over), int'(if7.winner));
    check_dut(1, int'(if79.p1_ones), int'(if79.p1_tens), int'(if79.p2_ones), int'(if79.p2_tens),
              int'(if79.serve), int'(if79.game_over), int'(if79.winner));
  endtask

  // Pulse one player's sensor for a cycle, then wait out the lockout.
  task automatic goal(input int d, input int pl);
    if (pl == 1) p1[d] = 1'b1; else p2[d] = 1'b1;
    cycle();
    p1[d] = 1'b0;
    p2[d] = 1'b0;
    repeat (LOCK + 2) cycle();
  endtask

  initial begin
    int first_serve;
    int s0;
    n_tests = 0;
    n_fail  = 0;
    win_of[0] = 7;
    win_of[1] = 79;
    n_serve[0] = 0;
    n_serve[1] = 0;
    rstn = 2'b00;
    p1 = 2'b00;
    p2 = 2'b00;
    clr = 2'b00;

    // Reset
    repeat (2) cycle();
    check("rst.p1_ones", int'(if7.p1_ones), 0);
    check("rst.game_over", int'(if79.game_over), 0);
    check("rst.winner", int'(if7.winner), 0);
    rstn = 2'b11;
    cycle();

    // Held P1 level scores once; serve 16 cycles after entering lockout
    first_serve = -1;
    s0 = n_serve[0];
    for (int i = 0; i < 40; i++) begin
      p1[0] = 1'b1;
      cycle();
      if (if7.serve && first_serve < 0) first_serve = i;
    end
    p1[0] = 1'b0;
    cycle();
    check("held.p1_ones", int'(if7.p1_ones), 1);
    check("held.serve_at", first_serve, LOCK);
    check("held.serve_cnt", n_serve[0] - s0, 1);

    // Simultaneous goals, then a new goal during lockout
    s0 = n_serve[0];
    p1[0] = 1'b1; p2[0] = 1'b1;
    cycle();
    p2[0] = 1'b0;
    cycle();
    p2[0] = 1'b1;
    cycle();
    p1[0] = 1'b0; p2[0] = 1'b0;
    repeat (20) cycle();
    check("both.p1_ones", int'(if7.p1_ones), 1);
    check("both.p2_ones", int'(if7.p2_ones), 0);
    check("both.serve_cnt", n_serve[0] - s0, 1);

    // BCD rollover and win at 79
    repeat (10) goal(1, 1);
    check("bcd.p1_tens", int'(if79.p1_tens), 1);
    check("bcd.p1_ones", int'(if79.p1_ones), 0);
    repeat (69) goal(1, 1);
    check("w79.game_over", int'(if79.game_over), 1);
    check("w79.winner", int'(if79.winner), 1);
    goal(1, 2);
    check("over.p2_ones", int'(if79.p2_ones), 0);
    check("over.p1_tens", int'(if79.p1_tens), 7);

    // Clear with p2 rising: clear wins, held level does not score afterwards
    clr[1] = 1'b1; p2[1] = 1'b1;
    cycle();
    clr[1] = 1'b0;
    repeat (3) cycle();
    p2[1] = 1'b0;
    cycle();
    check("clr.p2_ones", int'(if79.p2_ones), 0);
    check("clr.p1_tens", int'(if79.p1_tens), 0);
    check("clr.game_over", int'(if79.game_over), 0);

    // P2 wins at 7, then reset in OVER
    clr[0] = 1'b1;
    cycle();
    clr[0] = 1'b0;
    repeat (7) goal(0, 2);
    check("w7.game_over", int'(if7.game_over), 1);
    check("w7.winner", int'(if7.winner), 2);
    check("w7.p2_ones", int'(if7.p2_ones), 7);
    s0 = n_serve[0];
    rstn[0] = 1'b0;
    repeat (2) cycle();
    rstn[0] = 1'b1;
    repeat (20) cycle();
    check("rst_over.game_over", int'(if7.game_over), 0);
    check("rst_over.p2_ones", int'(if7.p2_ones), 0);
    check("rst_over.serve_cnt", n_serve[0] - s0, 0);

    // Randomized play on both instances
    for (int i = 0; i < 4000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 5) == 0) p1[d] = ~p1[d];
        if ($urandom_range(0, 5) == 0) p2[d] = ~p2[d];
        clr[d]  = ($urandom_range(0, 299) == 0);
        rstn[d] = ($urandom_range(0, 599) != 0);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
